// File: rtl/rom_fetch_pkg.sv
// Shared definitions for the instruction-fetch block: FSM encoding and PC increment.
package rom_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with registered pointers and count.
// Flush has priority over push and pop.
module fetch_fifo #(
  parameter int unsigned WIDTH = 40,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic [CNT_W-1:0] o_count,
  output logic [CNT_W-1:0] o_count_next,
  output logic             o_full
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (i_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (i_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (i_push && !i_pop)      count_d = count_q + CNT_W'(1);
      else if (i_pop && !i_push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; an entry is only ever observed while count says it is live.
  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush) mem_q[wr_ptr_q] <= i_wdata;
  end

  assign o_rdata      = mem_q[rd_ptr_q];
  assign o_count      = count_q;
  assign o_count_next = count_d;
  assign o_full       = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/rom_fetch.sv
// Instruction-fetch initiator: owns the PC, reads the combinational ROM into a
// prefetch FIFO and presents {instr, pc} to the core over valid/ready.
module rom_fetch
  import rom_fetch_pkg::*;
#(
  parameter int unsigned             DATA_WIDTH = 32,
  parameter int unsigned             ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0]   RESET_PC   = '0,
  parameter int unsigned             FIFO_DEPTH = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_fetch_en,
  input  logic                  i_redirect,
  input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
  output logic [ADDR_WIDTH-1:0] o_rom_addr,
  output logic                  o_rom_rd_en,
  output logic                  o_rom_ce,
  input  logic [DATA_WIDTH-1:0] i_rom_data,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_instr,
  output logic [ADDR_WIDTH-1:0] o_pc,
  input  logic                  i_ready
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned ENT_W = DATA_WIDTH + ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  state_e                state_q, state_d;
  logic                  push, pop, full;
  logic [CNT_W-1:0]      count, count_next;
  logic [ENT_W-1:0]      head;

  // Push is judged on the registered count, and is held off while reset is asserted.
  assign push = ~i_rst & i_fetch_en & ~i_redirect & ~full;
  assign pop  = o_valid & i_ready & ~i_redirect;

  fetch_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_push       (push),
    .i_pop        (pop),
    .i_flush      (i_redirect),
    .i_wdata      ({i_rom_data, pc_q}),
    .o_rdata      (head),
    .o_count      (count),
    .o_count_next (count_next),
    .o_full       (full)
  );

  always_comb begin
    pc_d = pc_q;
    if (i_redirect)  pc_d = {i_redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    else if (push)   pc_d = pc_q + ADDR_WIDTH'(PC_STEP);
  end

  always_comb begin
    state_d = state_q;
    if (!i_fetch_en) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:  state_d = ST_FETCH;
        ST_FETCH: if (count_next == CNT_W'(FIFO_DEPTH)) state_d = ST_FULL;
        ST_FULL:  if (count_next <  CNT_W'(FIFO_DEPTH)) state_d = ST_FETCH;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pc_q    <= RESET_PC;
      state_q <= ST_IDLE;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  assign o_rom_addr  = pc_q;
  assign o_rom_ce    = push;
  assign o_rom_rd_en = push;

  assign o_valid = (count != '0);
  assign o_instr = o_valid ? head[ENT_W-1:ADDR_WIDTH] : '0;
  assign o_pc    = o_valid ? head[ADDR_WIDTH-1:0]     : '0;

endmodule

// File: tb/tb_rom_fetch.sv
// Directed, table-driven bench for rom_fetch with a combinational ROM model.
module tb_rom_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en, redirect, ready;
  logic [7:0]  redirect_pc;
  logic [7:0]  rom_addr;
  logic        rom_rd_en, rom_ce;
  logic [31:0] rom_data;
  logic        valid;
  logic [31:0] instr;
  logic [7:0]  pc;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // ROM word at index k is 0x1000_0000 + k; zero unless selected.
  assign rom_data = (rom_ce && rom_rd_en) ? (32'h1000_0000 | {26'd0, rom_addr[7:2]}) : 32'd0;

  rom_fetch #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (8),
    .RESET_PC   (8'h00),
    .FIFO_DEPTH (2)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_fetch_en    (fetch_en),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_rom_addr    (rom_addr),
    .o_rom_rd_en   (rom_rd_en),
    .o_rom_ce      (rom_ce),
    .i_rom_data    (rom_data),
    .o_valid       (valid),
    .o_instr       (instr),
    .o_pc          (pc),
    .i_ready       (ready)
  );

  typedef struct {
    logic        fe;
    logic        rdy;
    logic        rd;
    logic [7:0]  rd_pc;
    logic        e_valid;
    logic [7:0]  e_pc;
    logic [31:0] e_instr;
    logic        e_ce;
    logic [7:0]  e_addr;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic e_valid, input logic [7:0] e_pc,
                               input logic [31:0] e_instr, input logic e_ce, input logic [7:0] e_addr);
    check({tag, ".valid"}, 32'(valid),     32'(e_valid));
    check({tag, ".pc"},    32'(pc),        32'(e_pc));
    check({tag, ".instr"}, instr,          e_instr);
    check({tag, ".ce"},    32'(rom_ce),    32'(e_ce));
    check({tag, ".rd_en"}, 32'(rom_rd_en), 32'(e_ce));
    check({tag, ".addr"},  32'(rom_addr),  32'(e_addr));
  endtask

  function automatic logic [31:0] w(input int k);
    return 32'h1000_0000 + 32'(k);
  endfunction

  initial begin
    // fe rdy rd rd_pc | valid pc instr ce addr
    vecs.push_back('{0, 0, 0, 8'h00, 0, 8'h00, 32'd0, 0, 8'h00}); // 0 idle after reset
    vecs.push_back('{1, 1, 0, 8'h00, 0, 8'h00, 32'd0, 1, 8'h00}); // 1 first read
    vecs.push_back('{1, 1, 0, 8'h00, 1, 8'h00, w(0),  1, 8'h04}); // 2 first valid
    vecs.push_back('{1, 1, 0, 8'h00, 1, 8'h04, w(1),  1, 8'h08});
    vecs.push_back('{1, 1, 0, 8'h00, 1, 8'h08, w(2),  1, 8'h0C});
    vecs.push_back('{0, 1, 0, 8'h00, 1, 8'h0C, w(3),  0, 8'h10}); // 5 fetch_en off, drain
    vecs.push_back('{0, 1, 0, 8'h00, 0, 8'h00, 32'd0, 0, 8'h10});
    vecs.push_back('{1, 0, 0, 8'h00, 0, 8'h00, 32'd0, 1, 8'h10}); // 7 ready low x6
    vecs.push_back('{1, 0, 0, 8'h00, 1, 8'h10, w(4),  1, 8'h14});
    vecs.push_back('{1, 0, 0, 8'h00, 1, 8'h10, w(4),  0, 8'h18});
    vecs.push_back('{1, 0, 0, 8'h00, 1, 8'h10, w(4),  0, 8'h18});
    vecs.push_back('{1, 0, 0, 8'h00, 1, 8'h10, w(4),  0, 8'h18});
    vecs.push_back('{1, 0, 0, 8'h00, 1, 8'h10, w(4),  0, 8'h18});
    vecs.push_back('{1, 1, 0, 8'h00, 1, 8'h10, w(4),  0, 8'h18}); // 13 ready back, full
    vecs.push_back('{1, 1, 0, 8'h00, 1, 8'h14, w(5),  1, 8'h18});
    vecs.push_back('{1, 1, 0, 8'h00, 1, 8'h18, w(6),  1, 8'h1C});
    vecs.push_back('{1, 0, 0, 8'h00, 1, 8'h1C, w(7),  1, 8'h20}); // 16 refill
    vecs.push_back('{1, 0, 0, 8'h00, 1, 8'h1C, w(7),  0, 8'h24});
    vecs.push_back('{1, 0, 1, 8'h13, 1, 8'h1C, w(7),  0, 8'h24}); // 18 redirect to 0x13 when full
    vecs.push_back('{1, 1, 0, 8'h00, 0, 8'h00, 32'd0, 1, 8'h10});
    vecs.push_back('{1, 1, 0, 8'h00, 1, 8'h10, w(4),  1, 8'h14});
    vecs.push_back('{1, 1, 1, 8'h20, 1, 8'h14, w(5),  0, 8'h18}); // 21 redirect with ready
    vecs.push_back('{1, 1, 0, 8'h00, 0, 8'h00, 32'd0, 1, 8'h20});
    vecs.push_back('{1, 1, 0, 8'h00, 1, 8'h20, w(8),  1, 8'h24});
    vecs.push_back('{1, 1, 1, 8'hF8, 1, 8'h24, w(9),  0, 8'h28}); // 24 redirect near top
    vecs.push_back('{1, 1, 0, 8'h00, 0, 8'h00, 32'd0, 1, 8'hF8});
    vecs.push_back('{1, 1, 0, 8'h00, 1, 8'hF8, w(62), 1, 8'hFC});
    vecs.push_back('{1, 1, 0, 8'h00, 1, 8'hFC, w(63), 1, 8'h00}); // 27 wrap
    vecs.push_back('{1, 1, 0, 8'h00, 1, 8'h00, w(0),  1, 8'h04});

    rst         = 1'b1;
    fetch_en    = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 8'h00;
    ready       = 1'b0;
    #12;
    check_outputs("reset", 1'b0, 8'h00, 32'd0, 1'b0, 8'h00);

    @(negedge clk);
    rst = 1'b0;
    foreach (vecs[i]) begin
      fetch_en    = vecs[i].fe;
      ready       = vecs[i].rdy;
      redirect    = vecs[i].rd;
      redirect_pc = vecs[i].rd_pc;
      #1;
      check_outputs($sformatf("v%0d", i), vecs[i].e_valid, vecs[i].e_pc,
                    vecs[i].e_instr, vecs[i].e_ce, vecs[i].e_addr);
      @(negedge clk);
    end

    // Asynchronous reset between edges while the FIFO holds a word.
    fetch_en = 1'b1;
    ready    = 1'b1;
    redirect = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_outputs("async_rst", 1'b0, 8'h00, 32'd0, 1'b0, 8'h00);
    @(negedge clk);
    check_outputs("rst_held", 1'b0, 8'h00, 32'd0, 1'b0, 8'h00);
    rst = 1'b0;
    #1;
    check_outputs("rst_rel", 1'b0, 8'h00, 32'd0, 1'b1, 8'h00);
    @(negedge clk);
    check_outputs("rst_rel1", 1'b1, 8'h00, w(0), 1'b1, 8'h04);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_fetch.md
# rom_fetch

Instruction-fetch initiator that drives the combinational instruction ROM port and delivers a stream of instruction words, each tagged with its PC, to the core over a valid/ready handshake. It owns the program counter, issues one ROM read per cycle while its prefetch FIFO has room, and supports a single-cycle redirect (branch/jump/trap) that flushes all prefetched words. It sits between the instruction ROM and the core decode stage.

## Interface
- DATA_WIDTH, 32, instruction word width; equals the ROM data width.
- ADDR_WIDTH, 8, byte-address width of the ROM port and of the PC.
- RESET_PC, 0, PC loaded on reset; bits [1:0] must be zero.
- FIFO_DEPTH, 2, prefetch entries; power of two, minimum 2.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_fetch_en  in  1  when low, no new ROM reads are issued; the FIFO still drains.
- i_redirect  in  1  one-cycle pulse: flush the FIFO and load the PC from i_redirect_pc.
- i_redirect_pc  in  ADDR_WIDTH  redirect target byte address.
- o_rom_addr  out  ADDR_WIDTH  byte address to the ROM; the ROM indexes its word array with addr[ADDR_WIDTH-1:2].
- o_rom_rd_en  out  1  ROM read enable.
- o_rom_ce  out  1  ROM chip enable.
- i_rom_data  in  DATA_WIDTH  ROM read data; combinational, valid in the same cycle as the address while ce and rd_en are high, and zero otherwise.
- o_valid  out  1  FIFO head holds an instruction.
- o_instr  out  DATA_WIDTH  head instruction word; zero when o_valid=0.
- o_pc  out  ADDR_WIDTH  byte address of the head instruction; zero when o_valid=0.
- i_ready  in  1  core accepts the head word this cycle.

## Operation
- State machine (2-bit), states IDLE, FETCH, FULL:
  - Reset enters IDLE.
  - IDLE → FETCH when i_fetch_en=1.
  - FETCH → FULL when the next-cycle count equals FIFO_DEPTH.
  - FULL → FETCH when the count drops below FIFO_DEPTH.
  - Any state → IDLE when i_fetch_en=0. Redirect does not change the state apart from the count update.
- Push condition: push = i_fetch_en & ~i_redirect & (count < FIFO_DEPTH). The condition is evaluated from registered count, so a simultaneous pop does not enable a push when the FIFO is full.
- ROM drive:
  - o_rom_ce = o_rom_rd_en = push.
  - o_rom_addr = pc at all times.
- On push:
  - Entry {i_rom_data, pc} is written at the write pointer.
  - pc <= pc + 4, modulo 2^ADDR_WIDTH. The top word wraps to address 0 with no flag.
- Pop condition: pop = o_valid & i_ready & ~i_redirect. Pop advances the read pointer.
- Redirect has priority over push and pop in the same cycle:
  - Pointers and count clear.
  - pc <= {i_redirect_pc[ADDR_WIDTH-1:2], 2'b00}; the low two bits are silently forced to zero.
  - The head word presented in that cycle is not considered accepted.
- Count is (FIFO_DEPTH's log2 + 1) bits wide. It changes +1 on push only, -1 on pop only, and is unchanged on push and pop together.
- o_valid = (count != 0). o_instr and o_pc are the head entry gated to zero when the FIFO is empty.
- Reset values:
  - pc = RESET_PC, count = 0, pointers = 0, state = IDLE.
  - o_valid = 0, o_instr = 0, o_pc = 0.
  - o_rom_ce = 0, o_rom_rd_en = 0, o_rom_addr = RESET_PC.
- Reset mid-stream discards all FIFO contents asynchronously.

## Timing
- Fetch-to-valid latency is 1 cycle: a word pushed in cycle N is visible at o_valid/o_instr in cycle N+1 if the FIFO was empty.
- With i_ready held high, sustained throughput is 1 instruction per cycle.
- After redirect in cycle N:
  - First ROM read at the target occurs in cycle N+1.
  - The target instruction is valid in cycle N+2.
  - No stale word is ever presented in cycle N+1.
- With i_ready held low, at most FIFO_DEPTH reads are issued and then o_rom_ce stays low. pc points to the first unfetched word.
- Deasserting i_fetch_en takes effect in the same cycle (no ROM read). The FIFO drains normally.

## Structure
- Shared package `rom_fetch_pkg`:
  - State enum (IDLE, FETCH, FULL).
  - Localparam PC_STEP = 4.
- One natural sub-module: `fetch_fifo`, a synchronous FIFO with registered pointers and count, and push, pop, and flush ports.
- The top level holds the pc register, the FSM, and the ROM-port drive.

## Test plan
- ROM words 0..7 = 0x1000_0000+index, RESET_PC=0, i_fetch_en=1, i_ready=1 → o_pc sequence 0x00,0x04,0x08,… with o_instr 0x1000_0000,0x1000_0001,…; o_valid first high in cycle 2 after reset release and then continuous.
- i_ready=0 for 6 cycles → exactly 2 ROM reads (o_rom_ce pulses), then o_rom_ce=0 and o_pc held at 0x00. After i_ready rises, words are delivered in order with no gap or duplicate.
- Redirect to 0x13 while the FIFO is full → next cycle o_valid=0 and o_rom_addr=0x10. The cycle after, o_pc=0x10 with o_instr=ROM word 4, and no pre-redirect word ever appears.
- PC at 0xFC with ADDR_WIDTH=8 → the fetch of 0xFC is followed by o_rom_addr=0x00 and the word sequence wraps correctly.
- Assert i_redirect and i_ready together while o_valid=1 → the head is not counted as accepted, and the flush and new PC behave as in the redirect scenario.
- Assert reset asynchronously mid-stream, between clock edges → o_valid, o_rom_ce, and o_instr go to zero immediately, and o_rom_addr becomes RESET_PC.
